// File: rtl/axi_sram_write_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_write_slave_pkg
//  Purpose  : Shared AXI field widths, encodings and FSM state type for the
//             SRAM-backed AXI write slave.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package axi_sram_write_slave_pkg;

   localparam int ID_W    = 8;
   localparam int ADDR_W  = 32;
   localparam int LEN_W   = 4;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int RESP_W  = 2;
   localparam int DATA_W  = 32;
   localparam int STRB_W  = DATA_W / 8;

   localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
   localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;

   localparam logic [RESP_W-1:0]  RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0]  RESP_SLVERR = 2'b10;

   localparam logic [SIZE_W-1:0]  SIZE_WORD   = 3'b010;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Only full-word beats and FIXED/INCR bursts are supported; anything else
   // is still consumed but answered with SLVERR and never written.
   function automatic logic aw_illegal(input logic [SIZE_W-1:0]  size,
                                       input logic [BURST_W-1:0] burst);
      return (size != SIZE_WORD) || burst[1];
   endfunction

endpackage : axi_sram_write_slave_pkg
`default_nettype wire

// File: rtl/axi_sram_write_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_write_slave_if
//  Purpose  : AXI write channels (AW/W/B) plus the single-port SRAM write
//             port of one SRAM-backed slave.
//  Modports : slave  - the write responder (drives READYs, B, SRAM pins)
//             master - the interconnect side / testbench
//  Revision : 1.0 - initial release
// ============================================================================
interface axi_sram_write_slave_if
   import axi_sram_write_slave_pkg::*;
#(
   parameter int SRAM_ADDR_BITS = 14
);

   // AW channel
   logic [ID_W-1:0]           AWID;
   logic [ADDR_W-1:0]         AWADDR;
   logic [LEN_W-1:0]          AWLEN;
   logic [SIZE_W-1:0]         AWSIZE;
   logic [BURST_W-1:0]        AWBURST;
   logic                      AWVALID;
   logic                      AWREADY;
   // W channel
   logic [DATA_W-1:0]         WDATA;
   logic [STRB_W-1:0]         WSTRB;
   logic                      WLAST;
   logic                      WVALID;
   logic                      WREADY;
   // B channel
   logic [ID_W-1:0]           BID;
   logic [RESP_W-1:0]         BRESP;
   logic                      BVALID;
   logic                      BREADY;
   // SRAM write port
   logic                      CEB;
   logic [STRB_W-1:0]         WEB;
   logic [SRAM_ADDR_BITS-1:0] A;
   logic [DATA_W-1:0]         DI;

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      output CEB, WEB, A, DI
   );

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      input  CEB, WEB, A, DI
   );

endinterface : axi_sram_write_slave_if
`default_nettype wire

// File: rtl/axi_sram_write_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi_sram_write_slave
//  Purpose  : AXI write responder for one single-port SRAM macro. Accepts one
//             AW request, sinks its W burst as byte-masked SRAM writes and
//             returns one B response. One transaction in flight.
//  Ports    : ACLK    - clock
//             ARESETn - synchronous active-low reset
//             bus     - AXI AW/W/B channels and SRAM write port (slave side)
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_write_slave
   import axi_sram_write_slave_pkg::*;
#(
   parameter int SRAM_ADDR_BITS = 14,
   parameter int ADDR_LSB       = 2
) (
   input  wire logic              ACLK,
   input  wire logic              ARESETn,
   axi_sram_write_slave_if.slave  bus
);

   state_t                    r_state,   w_state_nxt;
   logic                      r_awready, w_awready_nxt;
   logic                      r_wready,  w_wready_nxt;
   logic                      r_bvalid,  w_bvalid_nxt;
   logic [ID_W-1:0]           r_bid,     w_bid_nxt;
   logic [RESP_W-1:0]         r_bresp,   w_bresp_nxt;
   logic [SRAM_ADDR_BITS-1:0] r_addr,    w_addr_nxt;
   logic [LEN_W-1:0]          r_len,     w_len_nxt;
   logic [BURST_W-1:0]        r_burst,   w_burst_nxt;
   logic [LEN_W-1:0]          r_beat,    w_beat_nxt;
   logic                      r_err,     w_err_nxt;

   logic                      w_wr;
   logic                      w_unused;

   // A beat is accepted exactly when the W handshake completes.
   assign w_wr = bus.WVALID & r_wready;

   // Address bits outside the SRAM word window carry no information here.
   assign w_unused = &{1'b0, bus.AWADDR[ADDR_W-1:ADDR_LSB+SRAM_ADDR_BITS],
                       bus.AWADDR[ADDR_LSB-1:0]};

   // ------------------------------------------------------------------
   // Next-state and next-register logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_awready_nxt = r_awready;
      w_wready_nxt  = r_wready;
      w_bvalid_nxt  = r_bvalid;
      w_bid_nxt     = r_bid;
      w_bresp_nxt   = r_bresp;
      w_addr_nxt    = r_addr;
      w_len_nxt     = r_len;
      w_burst_nxt   = r_burst;
      w_beat_nxt    = r_beat;
      w_err_nxt     = r_err;

      unique case (r_state)
         IDLE: begin
            // Raising AWREADY here gives a ready address channel one cycle
            // after reset release without a separate reset-exit state.
            w_awready_nxt = 1'b1;
            if (bus.AWVALID && r_awready) begin
               w_bid_nxt     = bus.AWID;
               w_addr_nxt    = bus.AWADDR[ADDR_LSB +: SRAM_ADDR_BITS];
               w_len_nxt     = bus.AWLEN;
               w_burst_nxt   = bus.AWBURST;
               w_beat_nxt    = '0;
               w_err_nxt     = aw_illegal(bus.AWSIZE, bus.AWBURST);
               w_awready_nxt = 1'b0;
               w_wready_nxt  = 1'b1;
               w_state_nxt   = WRITE;
            end
         end

         WRITE: begin
            if (w_wr) begin
               if (r_beat != r_len) begin
                  w_beat_nxt = r_beat + 1'b1;
                  // Word address wraps naturally at the SRAM boundary.
                  if (r_burst == BURST_INCR) begin
                     w_addr_nxt = r_addr + 1'b1;
                  end
                  // The burst length comes from AWLEN only; a premature
                  // WLAST is flagged but the remaining beats are still sunk.
                  if (bus.WLAST) begin
                     w_err_nxt = 1'b1;
                  end
               end else begin
                  w_wready_nxt = 1'b0;
                  w_bvalid_nxt = 1'b1;
                  w_bresp_nxt  = (r_err || !bus.WLAST) ? RESP_SLVERR : RESP_OKAY;
                  w_state_nxt  = RESP;
               end
            end
         end

         RESP: begin
            if (r_bvalid && bus.BREADY) begin
               w_bvalid_nxt  = 1'b0;
               w_awready_nxt = 1'b1;
               w_state_nxt   = IDLE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_state   <= IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= RESP_OKAY;
         r_addr    <= '0;
         r_len     <= '0;
         r_burst   <= '0;
         r_beat    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_awready <= w_awready_nxt;
         r_wready  <= w_wready_nxt;
         r_bvalid  <= w_bvalid_nxt;
         r_bid     <= w_bid_nxt;
         r_bresp   <= w_bresp_nxt;
         r_addr    <= w_addr_nxt;
         r_len     <= w_len_nxt;
         r_burst   <= w_burst_nxt;
         r_beat    <= w_beat_nxt;
         r_err     <= w_err_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.AWREADY = r_awready;
   assign bus.WREADY  = r_wready;
   assign bus.BVALID  = r_bvalid;
   assign bus.BID     = r_bid;
   assign bus.BRESP   = r_bresp;

   // SRAM port follows the W handshake combinationally. Erroneous bursts
   // still select the macro but keep every byte lane masked.
   assign bus.CEB = ~w_wr;
   assign bus.WEB = (w_wr && !r_err) ? ~bus.WSTRB : {STRB_W{1'b1}};
   assign bus.A   = r_addr;
   assign bus.DI  = w_wr ? bus.WDATA : '0;

endmodule : axi_sram_write_slave
`default_nettype wire

// File: tb/tb_axi_sram_write_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_sram_write_slave
//  Purpose  : Directed self-checking bench for axi_sram_write_slave. Expected
//             SRAM writes and B responses are queued when stimulus is issued
//             and checked as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_write_slave;
   import axi_sram_write_slave_pkg::*;

   localparam int SAB = 14;

   typedef struct {
      logic [SAB-1:0]    a;
      logic [STRB_W-1:0] web;
      logic [DATA_W-1:0] di;
   } wr_t;

   typedef struct {
      logic [ID_W-1:0]   id;
      logic [RESP_W-1:0] resp;
   } b_t;

   logic ACLK    = 1'b0;
   logic ARESETn = 1'b0;
   always #5 ACLK = ~ACLK;

   axi_sram_write_slave_if #(.SRAM_ADDR_BITS(SAB)) bus ();

   axi_sram_write_slave #(
      .SRAM_ADDR_BITS (SAB),
      .ADDR_LSB       (2)
   ) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   wr_t wq[$];
   b_t  bq[$];
   int  n_cmp = 0;
   int  n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // SRAM-side scoreboard: every selected cycle must match the oldest
   // expected write; a select with nothing expected is an error.
   always @(negedge ACLK) begin : mon
      wr_t e;
      if (bus.CEB !== 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexpected_sram_ceb", {31'd0, bus.CEB}, 32'd1);
         end else begin
            e = wq.pop_front();
            chk("sram_a",   {18'd0, bus.A},   {18'd0, e.a});
            chk("sram_web", {28'd0, bus.WEB}, {28'd0, e.web});
            chk("sram_di",  bus.DI,           e.di);
         end
      end
   end

   // All tasks start and end at posedge+1.
   task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                        input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
      int n;
      bq.push_back('{id, resp});
      bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
      bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge ACLK);
         if (bus.AWREADY === 1'b1) break;
      end
      if (n == 50) begin
         chk("aw_timeout_awready", {31'd0, bus.AWREADY}, 32'd1);
         bus.AWVALID = 1'b0;
         return;
      end
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0;
      @(negedge ACLK);
      chk("wready_after_aw",  {31'd0, bus.WREADY},  32'd1);
      chk("awready_after_aw", {31'd0, bus.AWREADY}, 32'd0);
      @(posedge ACLK); #1;
   endtask

   task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                       input logic [SAB-1:0] a, input logic [3:0] web);
      int n;
      wq.push_back('{a, web, data});
      bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
      for (n = 0; n < 50; n++) begin
         @(negedge ACLK);
         if (bus.WREADY === 1'b1) break;
      end
      if (n == 50) chk("w_timeout_wready", {31'd0, bus.WREADY}, 32'd1);
      @(posedge ACLK); #1;
      bus.WVALID = 1'b0; bus.WLAST = 1'b0;
   endtask

   task automatic expect_b(input int stall);
      b_t e;
      bus.BREADY = 1'b0;
      @(negedge ACLK);
      chk("bvalid_latency", {31'd0, bus.BVALID}, 32'd1);
      e = bq.pop_front();
      chk("bid",   {24'd0, bus.BID},   {24'd0, e.id});
      chk("bresp", {30'd0, bus.BRESP}, {30'd0, e.resp});
      for (int i = 0; i < stall; i++) begin
         // A new request during the response phase must be ignored.
         bus.AWVALID = 1'b1; bus.AWID = 8'hEE;
         @(negedge ACLK);
         chk("bvalid_stall",  {31'd0, bus.BVALID},  32'd1);
         chk("bid_stall",     {24'd0, bus.BID},     {24'd0, e.id});
         chk("bresp_stall",   {30'd0, bus.BRESP},   {30'd0, e.resp});
         chk("awready_stall", {31'd0, bus.AWREADY}, 32'd0);
      end
      bus.AWVALID = 1'b0;
      bus.BREADY  = 1'b1;
      @(posedge ACLK); #1;
      bus.BREADY = 1'b0;
      @(negedge ACLK);
      chk("bvalid_after_b",  {31'd0, bus.BVALID},  32'd0);
      chk("awready_after_b", {31'd0, bus.AWREADY}, 32'd1);
      @(posedge ACLK); #1;
   endtask

   initial begin
      bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0;
      bus.AWBURST = '0; bus.AWVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
      bus.BREADY = 1'b0;

      // Reset state
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
      chk("rst_wready",  {31'd0, bus.WREADY},  32'd0);
      chk("rst_bvalid",  {31'd0, bus.BVALID},  32'd0);
      chk("rst_bid",     {24'd0, bus.BID},     32'd0);
      chk("rst_bresp",   {30'd0, bus.BRESP},   32'd0);
      chk("rst_ceb",     {31'd0, bus.CEB},     32'd1);
      chk("rst_web",     {28'd0, bus.WEB},     32'hF);
      chk("rst_di",      bus.DI,               32'd0);
      ARESETn = 1'b1;
      @(negedge ACLK);
      chk("awready_after_rst", {31'd0, bus.AWREADY}, 32'd1);
      @(posedge ACLK); #1;

      // Single write
      do_aw(8'h12, 32'h0000_0010, 4'd0, SIZE_WORD, BURST_INCR, RESP_OKAY);
      do_w(32'hDEAD_BEEF, 4'hF, 1'b1, 14'h0004, 4'h0);
      expect_b(0);

      // INCR burst wrapping the SRAM space, with a W gap and a zero-strobe beat
      do_aw(8'h34, 32'h0000_FFF8, 4'd3, SIZE_WORD, BURST_INCR, RESP_OKAY);
      do_w(32'h1111_0000, 4'hF, 1'b0, 14'h3FFE, 4'h0);
      @(posedge ACLK); #1;
      do_w(32'h1111_0001, 4'hF, 1'b0, 14'h3FFF, 4'h0);
      do_w(32'h1111_0002, 4'hF, 1'b0, 14'h0000, 4'h0);
      do_w(32'h1111_0003, 4'h0, 1'b1, 14'h0001, 4'hF);
      expect_b(0);

      // FIXED burst with partial strobes
      do_aw(8'h56, 32'h0000_0020, 4'd2, SIZE_WORD, BURST_FIXED, RESP_OKAY);
      do_w(32'hA0A0_A0A0, 4'h1, 1'b0, 14'h0008, 4'hE);
      do_w(32'hB1B1_B1B1, 4'h2, 1'b0, 14'h0008, 4'hD);
      do_w(32'hC2C2_C2C2, 4'hC, 1'b1, 14'h0008, 4'h3);
      expect_b(0);

      // Illegal size: beats consumed, nothing written
      do_aw(8'h78, 32'h0000_0100, 4'd1, 3'b001, BURST_INCR, RESP_SLVERR);
      do_w(32'h0BAD_0000, 4'hF, 1'b0, 14'h0040, 4'hF);
      do_w(32'h0BAD_0001, 4'hF, 1'b1, 14'h0041, 4'hF);
      expect_b(0);

      // Early WLAST: burst still runs three beats, later beats masked
      do_aw(8'h9A, 32'h0000_0040, 4'd2, SIZE_WORD, BURST_INCR, RESP_SLVERR);
      do_w(32'hE000_0000, 4'hF, 1'b1, 14'h0010, 4'h0);
      do_w(32'hE000_0001, 4'hF, 1'b0, 14'h0011, 4'hF);
      do_w(32'hE000_0002, 4'hF, 1'b1, 14'h0012, 4'hF);
      expect_b(0);

      // 16-beat burst, then B backpressure with an ignored AW attempt
      do_aw(8'hF0, 32'h0000_0200, 4'd15, SIZE_WORD, BURST_INCR, RESP_OKAY);
      for (int i = 0; i < 16; i++) begin
         do_w($urandom, 4'hF, (i == 15), 14'h0080 + 14'(i), 4'h0);
      end
      expect_b(5);

      // Reset after beat 1 of a 4-beat burst
      do_aw(8'hBC, 32'h0000_0300, 4'd3, SIZE_WORD, BURST_INCR, RESP_OKAY);
      do_w(32'h5555_0000, 4'hF, 1'b0, 14'h00C0, 4'h0);
      do_w(32'h5555_0001, 4'hF, 1'b0, 14'h00C1, 4'h0);
      bq.delete();
      ARESETn = 1'b0;
      @(posedge ACLK); #1;
      bus.WDATA = 32'h5555_0002; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
      @(negedge ACLK);
      chk("midrst_wready",  {31'd0, bus.WREADY},  32'd0);
      chk("midrst_bvalid",  {31'd0, bus.BVALID},  32'd0);
      chk("midrst_ceb",     {31'd0, bus.CEB},     32'd1);
      chk("midrst_awready", {31'd0, bus.AWREADY}, 32'd0);
      ARESETn = 1'b1;
      bus.WVALID = 1'b0;
      @(negedge ACLK);
      chk("awready_after_midrst", {31'd0, bus.AWREADY}, 32'd1);
      chk("bvalid_after_midrst",  {31'd0, bus.BVALID},  32'd0);
      @(posedge ACLK); #1;

      // Recovery transaction
      do_aw(8'h01, 32'h0000_0004, 4'd0, SIZE_WORD, BURST_INCR, RESP_OKAY);
      do_w(32'h0123_4567, 4'hF, 1'b1, 14'h0001, 4'h0);
      expect_b(2);

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("sram_queue_drained", wq.size(), 32'd0);
      chk("b_queue_drained",    bq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so a stuck handshake still ends the run.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_axi_sram_write_slave
`default_nettype wire

// File: doc/axi_sram_write_slave.md
Name: axi_sram_write_slave

Overview:
- AXI slave-side write responder at the far end of the interconnect write-address path.
- Accepts one AW request, sinks the W burst, issues one B response.
- Translates accepted beats into byte-masked writes on a single-port SRAM macro.
- One transaction in flight; instantiated once per SRAM-backed slave port (e.g. IM/DM).

Parameters:
- SRAM_ADDR_BITS, 14, SRAM word-address width.
- ADDR_LSB, 2, byte-offset bits dropped from AWADDR (32-bit words).

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- AWID  in  8  ID from interconnect ({master tag, master ID})
- AWADDR  in  32  byte address
- AWLEN  in  4  beats-1
- AWSIZE  in  3  beat size; only 3'b010 legal
- AWBURST  in  2  00 FIXED, 01 INCR, others illegal
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- WDATA  in  32  write data
- WSTRB  in  4  byte strobes
- WLAST  in  1  last beat
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- BID  out  8  response ID
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  4  SRAM byte write enables, active-low
- A  out  SRAM_ADDR_BITS  SRAM word address
- DI  out  32  SRAM write data

Behaviour:
- Reset (ARESETn=0 at posedge):
  - state=IDLE.
  - AWREADY, WREADY, BVALID = 0.
  - BID = 0, BRESP = 00.
  - addr, beat count and error flags = 0.
  - Reset mid-burst or mid-response abandons the transaction; no further SRAM write and no B.
- State machine, all handshake outputs registered:
  - IDLE: AWREADY=1 from the first cycle after reset release. On AWVALID&AWREADY:
    - latch BID<=AWID, addr_q<=AWADDR[ADDR_LSB+:SRAM_ADDR_BITS], len_q<=AWLEN, burst_q<=AWBURST, beat<=0;
    - err_q<=(AWSIZE!=3'b010)|(AWBURST[1]==1);
    - AWREADY<=0, WREADY<=1, go WRITE.
  - WRITE: each WVALID&WREADY is one beat.
    - If beat!=len_q: beat<=beat+1; addr_q<=addr_q+1 when burst_q==INCR (wraps modulo 2^SRAM_ADDR_BITS), held when FIXED.
    - If beat==len_q: WREADY<=0, BVALID<=1, BRESP<=(err_q|~WLAST)?10:00, go RESP.
    - WLAST on a non-final beat sets err_q but does not shorten the burst.
  - RESP: BVALID held with stable BID/BRESP until BREADY. On handshake: BVALID<=0, AWREADY<=1, go IDLE.
- Latency: AW handshake at cycle T → WREADY=1 at T+1. Final W beat at T+k → BVALID at T+k+1. B handshake at U → AWREADY at U+1.
- AWVALID while not in IDLE is ignored; AWREADY=0.
- SRAM side is combinational, wr = WVALID&WREADY:
  - CEB = ~wr.
  - WEB = (wr & ~err_q) ? ~WSTRB : 4'hF.
  - A = addr_q.
  - DI = wr ? WDATA : 0.
  - Idle/reset values: CEB=1, WEB=F, DI=0.
- WSTRB=0 on a valid beat still counts as a beat; CEB=0, WEB=F, so nothing is written.
- AWLEN=0 gives a single beat. AWLEN=15 gives 16 beats.

Decomposition:
- Shared AXI package: ID/ADDR/LEN/SIZE/DATA/STRB widths, BURST_FIXED/INCR, RESP_OKAY/SLVERR, SIZE_WORD, state enum {IDLE, WRITE, RESP}.
- No sub-module needed; a single FSM plus datapath registers.

Test Plan:
- Single write:
  - Stimulus: AWID=8'h12, AWADDR=32'h0000_0010, AWLEN=0, INCR, SIZE=010; W beat WDATA=DEADBEEF, WSTRB=F, WLAST=1.
  - Response: A=4, WEB=0, CEB=0 for one cycle; BVALID next cycle with BID=12, BRESP=00.
- INCR burst with wrap and backpressure:
  - Stimulus: AWADDR=32'h0000_FFF8, AWLEN=3; WVALID low on the second cycle.
  - Response: A=3FFE,3FFF,0000,0001, no write during the gap; BRESP=00.
- FIXED burst with partial strobes:
  - Stimulus: AWADDR=32'h20, AWLEN=2, FIXED; WSTRB=1,2,C.
  - Response: A=8 on all beats, WEB=E,D,3.
- Illegal size:
  - Stimulus: AWSIZE=001, AWLEN=1.
  - Response: two beats accepted, WEB=F throughout; BRESP=10.
- Early WLAST:
  - Stimulus: AWLEN=2, WLAST on beat 0.
  - Response: three beats consumed; BRESP=10.
- B backpressure and mid-burst reset:
  - BREADY low 5 cycles → BVALID/BID/BRESP stable, AWREADY=0; BREADY=1 → AWREADY=1 next cycle.
  - Separately, ARESETn=0 after beat 1 of 4 → WREADY=0, BVALID=0, CEB=1; AWREADY=1 after release.
